// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: one byte per request, driven by external baud-generator strobes.
// Optional LSB-first support is compiled in with `define SPI_XFER_LSBFE_EN.
module spi_xfer_ctrl (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       spe_i,
  input  logic       mstr_i,
  input  logic       spiswai_i,
  input  logic [1:0] spi_mode_i,
  input  logic       send_data_i,
  input  logic [7:0] data_mosi_i,
  input  logic       lsbfe_i,
  input  logic       mosi_send_sclk_i,
  input  logic       mosi_send_sclk0_i,
  input  logic       miso_receive_sclk_i,
  input  logic       miso_receive_sclk0_i,
  input  logic       miso_i,
  output logic       ss_o,
  output logic       mosi_o,
  output logic       tip_o,
  output logic       receive_data_o,
  output logic [7:0] data_miso_o
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t     state, nxt;
  logic [7:0] tx_sr, rx_sr, rx_next;
  logic [2:0] tx_idx;
  logic [3:0] rx_cnt;
  logic       run_ok, send_tick, recv_tick, last_rx, start, tx_bit;

  assign run_ok    = spe_i & mstr_i &
                     ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));
  assign send_tick = mosi_send_sclk_i | mosi_send_sclk0_i;
  assign recv_tick = miso_receive_sclk_i | miso_receive_sclk0_i;
  assign last_rx   = recv_tick & (rx_cnt == 4'd7);
  assign start     = send_data_i & run_ok;

`ifdef SPI_XFER_LSBFE_EN
  logic lsb_q;
  assign tx_bit  = lsb_q ? tx_sr[tx_idx] : tx_sr[3'd7 - tx_idx];
  assign rx_next = lsb_q ? {miso_i, rx_sr[7:1]} : {rx_sr[6:0], miso_i};
`else
  logic unused_lsbfe;
  assign unused_lsbfe = lsbfe_i;
  assign tx_bit  = tx_sr[3'd7 - tx_idx];
  assign rx_next = {rx_sr[6:0], miso_i};
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt            = state;
    ss_o           = 1'b1;
    tip_o          = 1'b0;
    mosi_o         = 1'b0;
    receive_data_o = 1'b0;
    case (state)
      IDLE: if (start) nxt = XFER;
      XFER: begin
        ss_o   = 1'b0;
        tip_o  = 1'b1;
        mosi_o = tx_bit;
        // losing run permission wins over a completing strobe
        if (!run_ok)      nxt = IDLE;
        else if (last_rx) nxt = DONE;
      end
      DONE: begin
        receive_data_o = 1'b1;
        nxt            = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      tx_idx      <= 3'd0;
      rx_cnt      <= 4'd0;
      data_miso_o <= 8'h00;
`ifdef SPI_XFER_LSBFE_EN
      lsb_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          tx_sr  <= data_mosi_i;
          tx_idx <= 3'd0;
          rx_cnt <= 4'd0;
`ifdef SPI_XFER_LSBFE_EN
          lsb_q  <= lsbfe_i;
`endif
        end
        XFER: if (run_ok) begin
          // first bit is already on the line; only shift after it has been sampled
          if (send_tick && (rx_cnt != 4'd0) && (tx_idx < 3'd7))
            tx_idx <= tx_idx + 3'd1;
          if (recv_tick) begin
            rx_sr  <= rx_next;
            rx_cnt <= rx_cnt + 4'd1;
          end
          if (last_rx) data_miso_o <= rx_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed scoreboard bench for spi_xfer_ctrl with miso looped back to mosi.
// Expected bytes and bit streams are queued by stimulus and checked by a negedge monitor.
module tb_spi_xfer_ctrl;
  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       spe_i = 1'b1, mstr_i = 1'b1, spiswai_i = 1'b0;
  logic [1:0] spi_mode_i = 2'b00;
  logic       send_data_i = 1'b0;
  logic [7:0] data_mosi_i = 8'h00;
  logic       lsbfe_i = 1'b0;
  logic       mosi_send_sclk_i = 1'b0, mosi_send_sclk0_i = 1'b0;
  logic       miso_receive_sclk_i = 1'b0, miso_receive_sclk0_i = 1'b0;
  logic       miso_i;
  logic       ss_o, mosi_o, tip_o, receive_data_o;
  logic [7:0] data_miso_o;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_bits[$];

  assign miso_i = mosi_o;
  always #5 PCLK = ~PCLK;

  spi_xfer_ctrl dut (
    .PCLK(PCLK), .PRESET(PRESET), .spe_i(spe_i), .mstr_i(mstr_i), .spiswai_i(spiswai_i),
    .spi_mode_i(spi_mode_i), .send_data_i(send_data_i), .data_mosi_i(data_mosi_i),
    .lsbfe_i(lsbfe_i), .mosi_send_sclk_i(mosi_send_sclk_i), .mosi_send_sclk0_i(mosi_send_sclk0_i),
    .miso_receive_sclk_i(miso_receive_sclk_i), .miso_receive_sclk0_i(miso_receive_sclk0_i),
    .miso_i(miso_i), .ss_o(ss_o), .mosi_o(mosi_o), .tip_o(tip_o),
    .receive_data_o(receive_data_o), .data_miso_o(data_miso_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge PCLK); #1;
  endtask

  task automatic start(input logic [7:0] d);
    data_mosi_i = d; send_data_i = 1'b1; step(); send_data_i = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] d, input int n, input logic lsb);
    for (int i = 0; i < n; i++) exp_bits.push_back(lsb ? d[i] : d[7-i]);
  endtask

  // one receive strobe then one send strobe, alternating which strobe line is used
  task automatic pair(input int i);
    if (i % 2 == 0) miso_receive_sclk_i = 1'b1; else miso_receive_sclk0_i = 1'b1;
    step();
    miso_receive_sclk_i = 1'b0; miso_receive_sclk0_i = 1'b0;
    if (i % 2 == 0) mosi_send_sclk_i = 1'b1; else mosi_send_sclk0_i = 1'b1;
    step();
    mosi_send_sclk_i = 1'b0; mosi_send_sclk0_i = 1'b0;
  endtask

  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (tip_o && (miso_receive_sclk_i || miso_receive_sclk0_i)) begin
        if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("mosi_bit", mosi_o, exp_bits.pop_front());
      end
      if (receive_data_o) begin
        chk("done_ss", ss_o, 1);
        chk("done_tip", tip_o, 0);
        if (exp_bytes.size() == 0) chk("unexpected_done", 1, 0);
        else chk("data_miso", data_miso_o, exp_bytes.pop_front());
      end
    end
  end

  initial begin
    step(); step();
    chk("rst_ss", ss_o, 1);
    chk("rst_tip", tip_o, 0);
    chk("rst_mosi", mosi_o, 0);
    chk("rst_rd", receive_data_o, 0);
    chk("rst_data", data_miso_o, 8'h00);
    PRESET = 1'b0;
    step();

    // loopback A5, with an ignored FF request mid-transfer
    push_bits(8'hA5, 8, 1'b0);
    exp_bytes.push_back(8'hA5);
    start(8'hA5);
    chk("xfer_ss", ss_o, 0);
    chk("xfer_tip", tip_o, 1);
    for (int i = 0; i < 8; i++) begin
      pair(i);
      if (i == 2) begin
        data_mosi_i = 8'hFF; send_data_i = 1'b1; step(); send_data_i = 1'b0;
      end
    end
    chk("after_ss", ss_o, 1);
    chk("after_tip", tip_o, 0);

    // disabled: request ignored
    spe_i = 1'b0;
    start(8'h77);
    chk("dis_ss", ss_o, 1);
    chk("dis_tip", tip_o, 0);
    step();
    chk("dis_tip2", tip_o, 0);
    spe_i = 1'b1;

    // wait mode, stop-in-wait raised after 3 receive strobes
    spi_mode_i = 2'b01;
    push_bits(8'h5A, 3, 1'b0);
    start(8'h5A);
    for (int i = 0; i < 3; i++) pair(i);
    spiswai_i = 1'b1; step();
    chk("abort_ss", ss_o, 1);
    chk("abort_tip", tip_o, 0);
    chk("abort_data", data_miso_o, 8'hA5);
    step(); step();
    spiswai_i = 1'b0; spi_mode_i = 2'b00;

    // reset after 5 receive strobes, then a clean 3C transfer
    push_bits(8'hC3, 5, 1'b0);
    start(8'hC3);
    for (int i = 0; i < 5; i++) pair(i);
    PRESET = 1'b1; step();
    chk("mid_rst_ss", ss_o, 1);
    chk("mid_rst_tip", tip_o, 0);
    chk("mid_rst_mosi", mosi_o, 0);
    chk("mid_rst_rd", receive_data_o, 0);
    chk("mid_rst_data", data_miso_o, 8'h00);
    PRESET = 1'b0; step();
    push_bits(8'h3C, 8, 1'b0);
    exp_bytes.push_back(8'h3C);
    start(8'h3C);
    for (int i = 0; i < 8; i++) pair(i);

    // bit order request: honoured only when the option is compiled in
    lsbfe_i = 1'b1;
`ifdef SPI_XFER_LSBFE_EN
    push_bits(8'h01, 8, 1'b1);
`else
    push_bits(8'h01, 8, 1'b0);
`endif
    exp_bytes.push_back(8'h01);
    start(8'h01);
    for (int i = 0; i < 8; i++) pair(i);
    lsbfe_i = 1'b0;

    step(); step(); step();
    chk("bits_drained", exp_bits.size(), 0);
    chk("bytes_drained", exp_bytes.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on PCLK rising edge.
REQ-002 PCLK  in  1  system clock.
REQ-003 PRESET  in  1  synchronous active-high reset.
REQ-004 spe_i, mstr_i, spiswai_i  in  1 each  SPI enable, master select, stop-in-wait.
REQ-005 spi_mode_i  in  2  00 run, 01 wait, 1x stop.
REQ-006 send_data_i  in  1  one-cycle transfer request; data_mosi_i  in  8  byte to send.
REQ-007 lsbfe_i  in  1  1 = LSB first (honoured only per REQ-031).
REQ-008 mosi_send_sclk_i, mosi_send_sclk0_i, miso_receive_sclk_i, miso_receive_sclk0_i  in  1 each  baud-generator edge strobes.
REQ-009 miso_i  in  1  serial input.
REQ-010 ss_o  out  1  active-low slave select; mosi_o  out  1  serial output.
REQ-011 tip_o  out  1  transfer in progress; receive_data_o  out  1  one-cycle done pulse; data_miso_o  out  8  received byte.

Function
REQ-012 SHALL define run_ok = spe_i & mstr_i & (spi_mode_i==00 | (spi_mode_i==01 & !spiswai_i)).
REQ-013 SHALL define send_tick = mosi_send_sclk_i | mosi_send_sclk0_i and recv_tick = miso_receive_sclk_i | miso_receive_sclk0_i.
REQ-014 SHALL implement FSM states IDLE, XFER, DONE.
REQ-015 IDLE: ss_o=1, tip_o=0, mosi_o=0; on send_data_i & run_ok -> XFER, tx shift register <= data_mosi_i, tx_idx=0, rx_cnt=0.
REQ-016 send_data_i with run_ok=0, or while in XFER/DONE, SHALL be ignored (no queuing).
REQ-017 XFER: ss_o=0, tip_o=1, both registered and valid the first cycle in XFER.
REQ-018 mosi_o SHALL present tx bit (7 - tx_idx) MSB-first, valid from first XFER cycle (satisfies CPHA=0 setup).
REQ-019 tx_idx SHALL advance on send_tick only when rx_cnt != 0 and tx_idx < 7; otherwise hold.
REQ-020 On recv_tick, miso_i SHALL shift into rx register and rx_cnt (4-bit) SHALL increment.
REQ-021 Simultaneous send_tick and recv_tick SHALL both take effect; advance test uses pre-edge rx_cnt.
REQ-022 On the 8th recv_tick -> DONE; data_miso_o <= assembled byte on that edge.
REQ-023 DONE: receive_data_o=1 for exactly one cycle, ss_o=1, tip_o=0; unconditional -> IDLE next cycle.
REQ-024 run_ok falling in XFER SHALL abort -> IDLE next cycle, ss_o=1, no receive_data_o, data_miso_o unchanged.
REQ-025 Minimum request-to-request spacing SHALL be DONE+IDLE = 2 cycles after the 8th recv_tick.
REQ-026 data_miso_o SHALL hold last completed byte until next completion.

Reset
REQ-027 PRESET high SHALL force IDLE, ss_o=1, mosi_o=0, tip_o=0, receive_data_o=0, data_miso_o=8'h00, counters and shift registers 0.
REQ-028 PRESET asserted mid-XFER SHALL take priority over all strobes; no done pulse generated.
REQ-029 Reset SHALL be sampled only on PCLK rising edge.

Configuration
REQ-030 Macro SPI_XFER_LSBFE_EN SHALL control bit-order support.
REQ-031 Defined: lsbfe_i sampled at XFER entry; 1 -> mosi_o sends bit tx_idx, rx shifts right so first received bit lands in bit 0.
REQ-032 Undefined: lsbfe_i ignored; MSB-first always, first received bit lands in bit 7.

Verification
REQ-033 data_mosi_i=8'hA5, miso_i looped to mosi_o, 8 send/recv tick pairs -> mosi_o sequence 1,0,1,0,0,1,0,1; data_miso_o=8'hA5; one receive_data_o pulse.
REQ-034 spe_i=0 with send_data_i=1 -> stays IDLE, ss_o=1, tip_o=0.
REQ-035 spi_mode_i=01, spiswai_i driven 1 after 3 recv_ticks -> IDLE next cycle, ss_o=1, no done pulse, data_miso_o keeps prior value.
REQ-036 PRESET=1 after 5 recv_ticks -> all outputs at reset values next edge; new 8'h3C transfer then completes correctly.
REQ-037 SPI_XFER_LSBFE_EN defined, lsbfe_i=1, data_mosi_i=8'h01, loopback -> mosi_o first bit 1 then seven 0s; data_miso_o=8'h01.
REQ-038 send_data_i pulsed again in XFER with 8'hFF -> ignored; transmitted byte remains original.
